// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes five sources, latches pending bits per edge/level
// mode, and hands the lowest-index enabled pending source to the core via req/ack/done.
module irq_controller #(
    parameter int unsigned NUM_SRC  = 5,
    parameter int unsigned ID_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  src_in,
    output logic                irq_o,
    input  logic                irq_ack,
    output logic [ID_WIDTH-1:0] irq_id,
    input  logic                irq_done,
    output logic                in_service,
    input  logic [1:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    input  logic                reg_we,
    input  logic                reg_re,
    output logic [31:0]         reg_rdata
);

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STAT_SVC    = 8;
    localparam int unsigned STAT_IRQ    = 9;
    localparam logic [1:0]  ADDR_ENABLE = 2'd0;
    localparam logic [1:0]  ADDR_PEND   = 2'd1;
    localparam logic [1:0]  ADDR_MODE   = 2'd2;
    localparam logic [1:0]  ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_SRC-1:0]  sync1, sync2, dly;
    logic [NUM_SRC-1:0]  enable, mode, pending;
    logic [NUM_SRC-1:0]  set_mask, w1c_mask, ack_mask, pend_en, pending_next;
    logic [ID_WIDTH-1:0] win_id, irq_id_next;
    logic                win_valid;
    logic                irq_next, in_service_next;
    logic [DATA_W-1:0]   rdata_c;
    logic                unused_wdata;

    assign unused_wdata = ^reg_wdata[DATA_W-1:NUM_SRC];

    // Two-flop synchronizer plus a delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
        end else begin
            sync1 <= src_in;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign set_mask = sync2 & (mode | ~dly);
    assign w1c_mask = (reg_we && (reg_addr == ADDR_PEND)) ? reg_wdata[NUM_SRC-1:0] : '0;
    assign pend_en  = pending & enable;

    // Fixed priority: the lowest set index is assigned last and therefore wins
    always_comb begin
        win_id    = '0;
        win_valid = |pend_en;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                win_id = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        irq_id_next = irq_id;
        ack_mask    = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (irq_ack && win_valid) begin
                    state_next  = SERVICE;
                    irq_id_next = win_id;
                    ack_mask    = NUM_SRC'(1) << win_id;
                end else if (!win_valid) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        irq_next        = (state_next == REQ);
        in_service_next = (state_next == SERVICE);
    end

    // Set beats software clear; the claim clears the bit so a level source re-sets a cycle later
    assign pending_next = ((pending & ~w1c_mask) | set_mask) & ~ack_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_o      <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
        end else begin
            irq_o      <= irq_next;
            in_service <= in_service_next;
            irq_id     <= irq_id_next;
            pending    <= pending_next;
            if (reg_we && (reg_addr == ADDR_ENABLE)) begin
                enable <= reg_wdata[NUM_SRC-1:0];
            end
            if (reg_we && (reg_addr == ADDR_MODE)) begin
                mode <= reg_wdata[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        case (reg_addr)
            ADDR_ENABLE: rdata_c[NUM_SRC-1:0] = enable;
            ADDR_PEND:   rdata_c[NUM_SRC-1:0] = pending;
            ADDR_MODE:   rdata_c[NUM_SRC-1:0] = mode;
            ADDR_STATUS: begin
                rdata_c[ID_WIDTH-1:0] = irq_id;
                rdata_c[STAT_SVC]     = in_service;
                rdata_c[STAT_IRQ]     = irq_o;
            end
            default: rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rdata_c;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, scoreboarded reads and
// hand-written sequences for edge/level sources, priority, W1C and reset.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  src_in;
    logic        irq_o;
    logic        irq_ack;
    logic [2:0]  irq_id;
    logic        irq_done;
    logic        in_service;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    irq_controller #(.NUM_SRC(5), .ID_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .src_in(src_in), .irq_o(irq_o),
        .irq_ack(irq_ack), .irq_id(irq_id), .irq_done(irq_done),
        .in_service(in_service), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_we = 1'b1;
        cyc();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        reg_addr = a; reg_re = 1'b1;
        e.name = name; e.exp = exp;
        sbq.push_back(e);
        cyc();
        reg_re = 1'b0;
        e = sbq.pop_front();
        chk(e.name, reg_rdata, e.exp);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
    endtask

    task automatic wait_irq(input int exp_n, input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (irq_o !== 1'b1 && n < 20);
        chk(name, n, exp_n);
    endtask

    initial begin
        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_001F};
        tbl[1] = '{2'd0, 32'h0000_000A, 32'h0000_000A};
        tbl[2] = '{2'd2, 32'h0000_0015, 32'h0000_0015};
        tbl[3] = '{2'd2, 32'hFFFF_FFE0, 32'h0000_0000};
        tbl[4] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{2'd1, 32'h0000_001F, 32'h0000_0000};
        tbl[6] = '{2'd0, 32'h0000_0000, 32'h0000_0000};

        reset = 1'b1; src_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
        reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0;
        cyc(); cyc();
        chk("rst_irq_o", irq_o, 0);
        chk("rst_in_service", in_service, 0);
        chk("rst_irq_id", irq_id, 0);
        chk("rst_rdata", reg_rdata, 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Single edge source: latency, claim, done
        wr(2'd0, 32'h1F);
        wr(2'd2, 32'h00);
        src_in = 5'b00001;
        repeat (3) cyc();
        src_in = '0;
        wait_irq(1, "s0_latency");
        rd(2'd1, 32'h01, "s0_pending");
        chk("s0_irq_still", irq_o, 1);
        pulse_ack();
        chk("s0_ack_irq_o", irq_o, 0);
        chk("s0_ack_svc", in_service, 1);
        chk("s0_ack_id", irq_id, 0);
        rd(2'd1, 32'h00, "s0_pend_clr");
        rd(2'd3, 32'h100, "s0_status");
        pulse_done();
        chk("s0_done_svc", in_service, 0);
        chk("s0_done_irq", irq_o, 0);

        // Two simultaneous edges: lower index claimed first
        src_in = 5'b01010;
        wait_irq(4, "s1_latency");
        pulse_ack();
        chk("s1_id_first", irq_id, 1);
        pulse_done();
        chk("s1_done_irq", irq_o, 0);
        cyc();
        chk("s1_reassert", irq_o, 1);
        pulse_ack();
        chk("s1_id_second", irq_id, 3);
        pulse_done();
        src_in = '0;
        repeat (3) cyc();
        chk("s1_quiet", irq_o, 0);

        // Disabled source latches pending; enabling then W1C in REQ
        wr(2'd0, 32'h00);
        src_in = 5'b00100;
        repeat (4) cyc();
        src_in = '0;
        chk("s2_disabled_irq", irq_o, 0);
        rd(2'd1, 32'h04, "s2_pending");
        wr(2'd0, 32'h04);
        chk("s2_en_edge", irq_o, 0);
        cyc();
        chk("s2_en_irq", irq_o, 1);
        wr(2'd1, 32'h04);
        cyc();
        chk("s2_w1c_idle", irq_o, 0);
        rd(2'd1, 32'h00, "s2_w1c_pend");

        // Level source repeats until it falls
        wr(2'd0, 32'h1F);
        wr(2'd2, 32'h02);
        src_in = 5'b00010;
        wait_irq(4, "s3_latency");
        for (int k = 0; k < 2; k++) begin
            pulse_ack();
            chk($sformatf("s3_id%0d", k), irq_id, 1);
            chk($sformatf("s3_svc%0d", k), in_service, 1);
            pulse_done();
            wait_irq(1, $sformatf("s3_relatch%0d", k));
        end
        src_in = '0;
        cyc(); cyc();
        pulse_ack();
        chk("s3_last_id", irq_id, 1);
        pulse_done();
        repeat (5) cyc();
        chk("s3_no_more", irq_o, 0);
        rd(2'd1, 32'h00, "s3_pend_empty");
        wr(2'd2, 32'h00);

        // Stray ack/done are ignored; reset during service
        pulse_ack();
        chk("s4_ack_idle_irq", irq_o, 0);
        chk("s4_ack_idle_svc", in_service, 0);
        rd(2'd3, 32'h001, "s4_status_idle");
        src_in = 5'b10000;
        wait_irq(4, "s4_latency");
        pulse_done();
        chk("s4_done_req_irq", irq_o, 1);
        chk("s4_done_req_svc", in_service, 0);
        src_in = '0;
        pulse_ack();
        chk("s4_svc", in_service, 1);
        chk("s4_id", irq_id, 4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s4_rst_svc", in_service, 0);
        chk("s4_rst_irq", irq_o, 0);
        chk("s4_rst_id", irq_id, 0);
        chk("s4_rst_rdata", reg_rdata, 0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), 32'h0, $sformatf("s4_rst_reg%0d", a));
        end

        // Set and W1C of bit 4 on the same edge: set wins
        src_in = 5'b10000;
        cyc(); cyc();
        wr(2'd1, 32'h10);
        rd(2'd1, 32'h10, "s5_set_wins");

        // Ack and W1C of the same bit on the same edge: bit cleared
        wr(2'd0, 32'h10);
        cyc();
        chk("s5_irq", irq_o, 1);
        irq_ack = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h10; reg_we = 1'b1;
        cyc();
        irq_ack = 1'b0; reg_we = 1'b0;
        chk("s5_svc", in_service, 1);
        chk("s5_id", irq_id, 4);
        rd(2'd1, 32'h00, "s5_ack_w1c");
        pulse_done();
        src_in = '0;
        repeat (3) cyc();
        chk("s5_quiet", irq_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
